// File: rtl/lsu_stage.sv
// Load/store unit stage: req/gnt/rvalid data bus master with load extension.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned requests instead of aligning down.
module lsu_stage #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  input  logic [2:0]            funct3_i,
  input  logic                  load_i,
  input  logic                  store_i,
  output logic [WORD_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_valid_o,
  output logic                  lsu_busy_o,
  output logic                  misaligned_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  input  logic [WORD_WIDTH-1:0] data_rdata_i,
  input  logic                  data_rvalid_i
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } state_e;

  state_e                state_q;
  logic                  req_q;
  logic                  we_q;
  logic                  valid_q;
  logic                  mis_q;
  logic [3:0]            be_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [WORD_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [WORD_WIDTH-1:0] rdata_q;

  logic                  is_b;
  logic                  is_h;
  logic                  misal;
  logic [1:0]            off_a;
  logic [3:0]            be_d;
  logic [WORD_WIDTH-1:0] wrep_d;
  logic                  req_v;
  logic                  accept;
  logic                  trap;
  logic [WORD_WIDTH-1:0] shifted;
  logic [WORD_WIDTH-1:0] ext_d;

  assign is_b  = (funct3_i[1:0] == 2'b00);
  assign is_h  = (funct3_i[1:0] == 2'b01);
  assign req_v = load_i | store_i;

  // Offset is the aligned-down lane, so misaligned H/W land on a legal lane.
  always_comb begin
    be_d   = 4'b1111;
    wrep_d = wdata_i;
    off_a  = 2'b00;
    misal  = 1'b0;
    unique case (1'b1)
      is_b: begin
        off_a  = addr_i[1:0];
        be_d   = 4'b0001 << off_a;
        wrep_d = {4{wdata_i[7:0]}};
      end
      is_h: begin
        misal  = addr_i[0];
        off_a  = {addr_i[1], 1'b0};
        be_d   = 4'b0011 << off_a;
        wrep_d = {2{wdata_i[15:0]}};
      end
      default: misal = |addr_i[1:0];
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign accept = req_v & ~misal;
  assign trap   = req_v & misal;
`else
  logic unused_misal;
  assign unused_misal = misal;
  assign accept = req_v;
  assign trap   = 1'b0;
`endif

  assign shifted = data_rdata_i >> {off_q, 3'b000};

  always_comb begin
    ext_d = shifted;
    case (f3_q)
      3'b000:  ext_d = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext_d = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext_d = {24'h0, shifted[7:0]};
      3'b101:  ext_d = {16'h0, shifted[15:0]};
      default: ext_d = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      be_q    <= 4'b0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          mis_q <= trap;
          if (accept) begin
            state_q <= WAIT_GNT;
            req_q   <= 1'b1;
            we_q    <= store_i;
            be_q    <= be_d;
            f3_q    <= funct3_i;
            off_q   <= off_a;
            addr_q  <= {addr_i[WORD_WIDTH-1:2], 2'b00};
            wdata_q <= wrep_d;
          end
        end
        WAIT_GNT: begin
          if (data_gnt_i) begin
            state_q <= WAIT_RVALID;
            req_q   <= 1'b0;
          end
        end
        WAIT_RVALID: begin
          if (data_rvalid_i) begin
            state_q <= IDLE;
            valid_q <= 1'b1;
            if (!we_q) rdata_q <= ext_d;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign lsu_rdata_o  = rdata_q;
  assign lsu_valid_o  = valid_q;
  assign lsu_busy_o   = (state_q != IDLE);
  assign misaligned_o = mis_q;
  assign data_req_o   = req_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: vector table plus hand-written multi-cycle sequences.
// Works with or without LSU_MISALIGN_TRAP_EN defined.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr_i, wdata_i;
  logic [2:0]  funct3_i;
  logic        load_i, store_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_valid_o, lsu_busy_o, misaligned_o;
  logic        data_req_o, data_gnt_i, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic        data_rvalid_i;

  lsu_stage #(.WORD_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .funct3_i     (funct3_i),
    .load_i       (load_i),
    .store_i      (store_i),
    .lsu_rdata_o  (lsu_rdata_o),
    .lsu_valid_o  (lsu_valid_o),
    .lsu_busy_o   (lsu_busy_o),
    .misaligned_o (misaligned_o),
    .data_req_o   (data_req_o),
    .data_gnt_i   (data_gnt_i),
    .data_we_o    (data_we_o),
    .data_be_o    (data_be_o),
    .data_addr_o  (data_addr_o),
    .data_wdata_o (data_wdata_o),
    .data_rdata_i (data_rdata_i),
    .data_rvalid_i(data_rvalid_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t        vq[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Called right after a negedge; returns at the negedge where valid is high.
  task automatic run(input vec_t v);
    load_i   = v.ld;
    store_i  = v.st;
    funct3_i = v.f3;
    addr_i   = v.addr;
    wdata_i  = v.wdata;
    @(negedge clk);
    load_i  = 1'b0;
    store_i = 1'b0;
    chk("req", data_req_o, 1);
    chk("addr", data_addr_o, v.e_addr);
    chk("be", data_be_o, v.e_be);
    chk("we", data_we_o, v.st);
    chk("busy1", lsu_busy_o, 1);
    chk("valid1", lsu_valid_o, 0);
    chk("mis1", misaligned_o, 0);
    if (v.st) chk("wdata", data_wdata_o, v.e_wdata);
    data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0;
    chk("req2", data_req_o, 0);
    chk("busy2", lsu_busy_o, 1);
    data_rvalid_i = 1'b1;
    data_rdata_i  = v.rdata;
    @(negedge clk);
    data_rvalid_i = 1'b0;
    chk("valid", lsu_valid_o, 1);
    chk("busy3", lsu_busy_o, 0);
    if (!v.st) last_rd = v.e_rdata;
    chk("rdata", lsu_rdata_o, last_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vq.push_back('{1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF,
                   32'h100, 4'b1111, 0, 32'hDEADBEEF});
    vq.push_back('{1, 0, 3'b000, 32'h203, 0, 32'h80FFFFFF,
                   32'h200, 4'b1000, 0, 32'hFFFFFF80});
    vq.push_back('{1, 0, 3'b100, 32'h203, 0, 32'h80FFFFFF,
                   32'h200, 4'b1000, 0, 32'h00000080});
    vq.push_back('{1, 0, 3'b001, 32'h202, 0, 32'h80011234,
                   32'h200, 4'b1100, 0, 32'hFFFF8001});
    vq.push_back('{1, 0, 3'b101, 32'h200, 0, 32'h8001F234,
                   32'h200, 4'b0011, 0, 32'h0000F234});
    vq.push_back('{0, 1, 3'b000, 32'h501, 32'h000000A5, 32'hFFFFFFFF,
                   32'h500, 4'b0010, 32'hA5A5A5A5, 0});
    vq.push_back('{0, 1, 3'b010, 32'h600, 32'h12345678, 32'hFFFFFFFF,
                   32'h600, 4'b1111, 32'h12345678, 0});
    vq.push_back('{1, 0, 3'b110, 32'h604, 0, 32'h87654321,
                   32'h604, 4'b1111, 0, 32'h87654321});
`ifndef LSU_MISALIGN_TRAP_EN
    vq.push_back('{1, 0, 3'b010, 32'h401, 0, 32'h11223344,
                   32'h400, 4'b1111, 0, 32'h11223344});
    vq.push_back('{1, 0, 3'b001, 32'h203, 0, 32'hABCD0000,
                   32'h200, 4'b1100, 0, 32'hFFFFABCD});
`endif

    rst_n = 1'b0;
    addr_i = 0; wdata_i = 0; funct3_i = 0;
    load_i = 0; store_i = 0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", data_req_o, 0);
    chk("rst_busy", lsu_busy_o, 0);
    chk("rst_valid", lsu_valid_o, 0);
    chk("rst_rdata", lsu_rdata_o, 0);
    chk("rst_addr", data_addr_o, 0);
    chk("rst_be", data_be_o, 0);
    chk("rst_mis", misaligned_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vq[i]) run(vq[i]);
    @(negedge clk);

    // SH with grant held off; stray rvalid during WAIT_GNT is ignored
    store_i = 1; funct3_i = 3'b001; addr_i = 32'h302; wdata_i = 32'h1234ABCD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      store_i = 0;
      chk("sh_req", data_req_o, 1);
      chk("sh_addr", data_addr_o, 32'h300);
      chk("sh_be", data_be_o, 4'b1100);
      chk("sh_wdata", data_wdata_o, 32'hABCDABCD);
      chk("sh_busy", lsu_busy_o, 1);
      data_rvalid_i = (i == 1);
      data_rdata_i  = 32'h55555555;
      data_gnt_i    = (i == 3);
    end
    @(negedge clk);
    data_gnt_i = 0;
    chk("sh_req_off", data_req_o, 0);
    chk("sh_busy_r", lsu_busy_o, 1);
    data_rvalid_i = 1;
    @(negedge clk);
    data_rvalid_i = 0;
    chk("sh_valid", lsu_valid_o, 1);
    chk("sh_busy_end", lsu_busy_o, 0);
    chk("sh_rdata_keep", lsu_rdata_o, last_rd);
    @(negedge clk);

    // Load+store together: store wins; a request while busy is dropped
    load_i = 1; store_i = 1; funct3_i = 3'b010;
    addr_i = 32'h700; wdata_i = 32'hCAFEF00D;
    @(negedge clk);
    store_i = 0;
    addr_i = 32'h800;
    chk("ls_we", data_we_o, 1);
    chk("ls_addr", data_addr_o, 32'h700);
    chk("ls_wdata", data_wdata_o, 32'hCAFEF00D);
    data_gnt_i = 1;
    @(negedge clk);
    data_gnt_i = 0;
    data_rvalid_i = 1; data_rdata_i = 32'h99999999;
    @(negedge clk);
    load_i = 0;
    data_rvalid_i = 0;
    chk("ls_valid", lsu_valid_o, 1);
    chk("ls_rdata", lsu_rdata_o, last_rd);
    @(negedge clk);
    chk("ls_no2_req", data_req_o, 0);
    chk("ls_no2_busy", lsu_busy_o, 0);
    chk("ls_addr_keep", data_addr_o, 32'h700);

`ifdef LSU_MISALIGN_TRAP_EN
    load_i = 1; funct3_i = 3'b010; addr_i = 32'h401;
    @(negedge clk);
    load_i = 0;
    chk("mis_pulse", misaligned_o, 1);
    chk("mis_req", data_req_o, 0);
    chk("mis_busy", lsu_busy_o, 0);
    @(negedge clk);
    chk("mis_end", misaligned_o, 0);
    chk("mis_valid", lsu_valid_o, 0);
    chk("mis_req2", data_req_o, 0);
`endif

    // Async reset while waiting for grant
    load_i = 1; funct3_i = 3'b010; addr_i = 32'h900;
    @(negedge clk);
    load_i = 0;
    chk("rr_req", data_req_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_req_drop", data_req_o, 0);
    chk("rr_busy_drop", lsu_busy_o, 0);
    chk("rr_rdata", lsu_rdata_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 32'h0;
    @(negedge clk);
    run(vq[0]);
    @(negedge clk);
    chk("post_valid", lsu_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
